lbp_host_if: RTL and testbench
==============================

Name: lbp_host_if

Overview:
- Host-side counterpart of the LBP engine's two memory interfaces.
- Holds the grayscale image: a host preloads it, then the engine reads it over gray_addr/gray_req/gray_data, gated by gray_ready.
- Captures the engine's LBP result stream (lbp_addr/lbp_valid/lbp_data/finish) into a result RAM. Tracks count, checksum and ordering errors, and exposes results to the host for readback.

Parameters:
- ADDR_W, 14, address width of both images.
- DATA_W, 8, pixel / LBP code width.
- DEPTH, 16384, pixels per image (must equal 2^ADDR_W).
- CSUM_W, 24, checksum accumulator width.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- load_valid  in  1  host preload beat valid
- load_data  in  DATA_W  host preload pixel
- load_ready  out  1  preload beat accepted when load_valid and load_ready are both high
- gray_addr  in  ADDR_W  engine read address
- gray_req  in  1  engine read request
- gray_ready  out  1  image fully loaded; engine may read
- gray_data  out  DATA_W  read data for gray_addr
- lbp_addr  in  ADDR_W  engine result address
- lbp_valid  in  1  engine result write strobe
- lbp_data  in  DATA_W  engine result code
- finish  in  1  engine completion
- rd_addr  in  ADDR_W  host result readback address
- rd_data  out  DATA_W  result RAM data, 1-cycle latency
- wr_cnt  out  ADDR_W+1  result beats accepted
- csum  out  CSUM_W  running sum of accepted lbp_data, mod 2^CSUM_W
- err_order  out  1  sticky: result address out of sequence
- err_early  out  1  sticky: lbp_valid seen outside SERVE
- err_count  out  1  sticky: finish with wr_cnt != DEPTH
- done  out  1  DONE state

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset values:
  - state=LOAD, load_ptr=0, exp_addr=0.
  - load_ready=1, gray_ready=0, done=0.
  - wr_cnt=0, csum=0, all err_*=0, rd_data=0.
  - RAM contents are not reset.
- FSM LOAD→SERVE→DONE:
  - LOAD: load_ready=1. On each accepted beat, gray_ram[load_ptr]<=load_data and load_ptr++. The beat with load_ptr==DEPTH-1 moves to SERVE next cycle; load_ptr wraps to 0.
  - SERVE: gray_ready=1, load_ready=0, load_valid ignored. On finish, move to DONE.
  - DONE: done=1, gray_ready stays 1, load_ready=0. The state is held until reset.
- Gray read path:
  - gray_data is combinational: gray_ram[gray_addr] when gray_req=1 and state!=LOAD, else 0.
  - It is valid in the same cycle the address is presented, because the engine samples at the next edge.
  - No request/acknowledge: gray_req only gates the data.
- Result capture:
  - In SERVE, lbp_valid=1 writes lbp_ram[lbp_addr]<=lbp_data, increments wr_cnt (saturates at DEPTH) and adds zero-extended lbp_data to csum (wraps).
  - Ordering: if lbp_addr!=exp_addr, set err_order; the write still happens. exp_addr<=lbp_addr+1, wrapping at DEPTH.
  - lbp_valid and finish in the same cycle: the beat is captured first, and the count check uses the post-increment wr_cnt.
  - lbp_valid in LOAD or DONE: no write, no count, err_early<=1.
  - finish in LOAD: ignored, err_early<=1.
  - finish in SERVE with final wr_cnt!=DEPTH: err_count<=1; DONE is still entered.
- Readback: rd_data<=lbp_ram[rd_addr] every cycle, in any state; valid one cycle after rd_addr.
- Reset mid-operation: all state and counters clear; the host must reload the image.

Test Plan:
- Preload gray_ram[i]=i[7:0] for all 16384 beats with load_valid held → load_ready drops and gray_ready=1 the cycle after beat 16383; gray_req=1, gray_addr=300 → gray_data=0x2C in the same cycle.
- In SERVE, drive 16384 in-order writes with lbp_data=0x01, then finish → wr_cnt=16384, csum=16384, done=1, all err_*=0; rd_addr=5 → rd_data=0x01 next cycle.
- Writes to addresses 0,1,3 → err_order=1 after the third beat; lbp_ram[3] is written; exp_addr=4.
- lbp_valid=1 with data 0xAA during LOAD (load_ptr=10) → err_early=1, wr_cnt=0, csum=0.
- Finish after 100 writes → err_count=1 and done=1; load_valid in DONE → load_ready=0, no RAM change.
- Assert reset mid-SERVE after 50 writes → next cycle state=LOAD, wr_cnt=0, gray_ready=0, load_ready=1.

Source files
------------

// File: rtl/lbp_host_if.sv
// Host-side memory interface for the LBP engine: gray image preload and
// engine read port, plus LBP result capture with count/checksum/order tracking.
module lbp_host_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16384,
  parameter int CSUM_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] gray_addr,
  input  logic              gray_req,
  output logic              gray_ready,
  output logic [DATA_W-1:0] gray_data,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic              lbp_valid,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   wr_cnt,
  output logic [CSUM_W-1:0] csum,
  output logic              err_order,
  output logic              err_early,
  output logic              err_count,
  output logic              done
);

  typedef enum logic [1:0] {ST_LOAD, ST_SERVE, ST_DONE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   load_ptr_q, load_ptr_d;
  logic [ADDR_W-1:0]   exp_addr_q, exp_addr_d;
  logic [ADDR_W:0]     wr_cnt_q, wr_cnt_d;
  logic [CSUM_W-1:0]   csum_q, csum_d;
  logic                err_order_q, err_order_d;
  logic                err_early_q, err_early_d;
  logic                err_count_q, err_count_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                gray_we, lbp_we;

  logic [DATA_W-1:0]   gray_ram [DEPTH];
  logic [DATA_W-1:0]   lbp_ram  [DEPTH];

  // Next-state, status updates and RAM write enables.
  always_comb begin
    state_d     = state_q;
    load_ptr_d  = load_ptr_q;
    exp_addr_d  = exp_addr_q;
    wr_cnt_d    = wr_cnt_q;
    csum_d      = csum_q;
    err_order_d = err_order_q;
    err_early_d = err_early_q;
    err_count_d = err_count_q;
    load_ready  = 1'b0;
    gray_ready  = 1'b0;
    done        = 1'b0;
    gray_we     = 1'b0;
    lbp_we      = 1'b0;
    case (state_q)
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          gray_we    = 1'b1;
          load_ptr_d = load_ptr_q + 1'b1;
          if (load_ptr_q == LAST_PTR) state_d = ST_SERVE;
        end
        if (lbp_valid || finish) err_early_d = 1'b1;
      end
      ST_SERVE: begin
        gray_ready = 1'b1;
        if (lbp_valid) begin
          lbp_we     = 1'b1;
          if (wr_cnt_q != DEPTH_CNT) wr_cnt_d = wr_cnt_q + 1'b1;
          csum_d     = csum_q + {{(CSUM_W-DATA_W){1'b0}}, lbp_data};
          if (lbp_addr != exp_addr_q) err_order_d = 1'b1;
          exp_addr_d = lbp_addr + 1'b1;
        end
        // A beat coinciding with finish is already counted in wr_cnt_d.
        if (finish) begin
          state_d = ST_DONE;
          if (wr_cnt_d != DEPTH_CNT) err_count_d = 1'b1;
        end
      end
      ST_DONE: begin
        gray_ready = 1'b1;
        done       = 1'b1;
        if (lbp_valid) err_early_d = 1'b1;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Control and status registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      load_ptr_q  <= '0;
      exp_addr_q  <= '0;
      wr_cnt_q    <= '0;
      csum_q      <= '0;
      err_order_q <= 1'b0;
      err_early_q <= 1'b0;
      err_count_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      load_ptr_q  <= load_ptr_d;
      exp_addr_q  <= exp_addr_d;
      wr_cnt_q    <= wr_cnt_d;
      csum_q      <= csum_d;
      err_order_q <= err_order_d;
      err_early_q <= err_early_d;
      err_count_q <= err_count_d;
      rd_data_q   <= lbp_ram[rd_addr];
    end
  end

  // Image and result RAM writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (gray_we) gray_ram[load_ptr_q] <= load_data;
    if (lbp_we)  lbp_ram[lbp_addr]    <= lbp_data;
  end

  assign gray_data = (gray_req && state_q != ST_LOAD) ? gray_ram[gray_addr] : '0;
  assign rd_data   = rd_data_q;
  assign wr_cnt    = wr_cnt_q;
  assign csum      = csum_q;
  assign err_order = err_order_q;
  assign err_early = err_early_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_lbp_host_if.sv
// Randomized bench for lbp_host_if with a behavioural reference model.
module tb_lbp_host_if;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16384;
  localparam int CSUM_W = 24;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load_valid = 1'b0;
  logic [DATA_W-1:0] load_data = '0;
  logic load_ready;
  logic [ADDR_W-1:0] gray_addr = '0;
  logic gray_req = 1'b0;
  logic gray_ready;
  logic [DATA_W-1:0] gray_data;
  logic [ADDR_W-1:0] lbp_addr = '0;
  logic lbp_valid = 1'b0;
  logic [DATA_W-1:0] lbp_data = '0;
  logic finish = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0] wr_cnt;
  logic [CSUM_W-1:0] csum;
  logic err_order, err_early, err_count, done;

  int nchk = 0;
  int nerr = 0;
  bit started = 1'b0;

  lbp_host_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CSUM_W(CSUM_W)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .gray_addr(gray_addr), .gray_req(gray_req), .gray_ready(gray_ready), .gray_data(gray_data),
    .lbp_addr(lbp_addr), .lbp_valid(lbp_valid), .lbp_data(lbp_data), .finish(finish),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_cnt(wr_cnt), .csum(csum),
    .err_order(err_order), .err_early(err_early), .err_count(err_count), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = loading, 1 = serving, 2 = finished.
  int mphase, mptr, mexp, mcnt, mcsum;
  bit eo, ee, ec;
  logic [DATA_W-1:0] gray_m [DEPTH];
  logic [DATA_W-1:0] lbp_m [DEPTH];
  bit lk [DEPTH];
  logic [DATA_W-1:0] mrd;
  bit mrd_known = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mphase = 0; mptr = 0; mexp = 0; mcnt = 0; mcsum = 0;
      eo = 0; ee = 0; ec = 0; mrd = '0; mrd_known = 1'b1;
    end else begin
      mrd = lbp_m[rd_addr];
      mrd_known = lk[rd_addr];
      if (mphase == 0) begin
        if (load_valid) begin
          gray_m[mptr] = load_data;
          if (mptr == DEPTH - 1) begin mphase = 1; mptr = 0; end
          else mptr = mptr + 1;
        end
        if (lbp_valid || finish) ee = 1;
      end else if (mphase == 1) begin
        if (lbp_valid) begin
          lbp_m[lbp_addr] = lbp_data;
          lk[lbp_addr] = 1'b1;
          if (int'(lbp_addr) != mexp) eo = 1;
          mexp = (int'(lbp_addr) + 1) % DEPTH;
          if (mcnt < DEPTH) mcnt = mcnt + 1;
          mcsum = (mcsum + int'(lbp_data)) % (1 << CSUM_W);
        end
        if (finish) begin
          if (mcnt != DEPTH) ec = 1;
          mphase = 2;
        end
      end else begin
        if (lbp_valid) ee = 1;
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      chk("load_ready", load_ready, mphase == 0);
      chk("gray_ready", gray_ready, mphase != 0);
      chk("done", done, mphase == 2);
      chk("wr_cnt", wr_cnt, mcnt);
      chk("csum", csum, mcsum);
      chk("err_order", err_order, eo);
      chk("err_early", err_early, ee);
      chk("err_count", err_count, ec);
      chk("gray_data", gray_data, (gray_req && mphase != 0) ? gray_m[gray_addr] : 8'h00);
      if (mrd_known) chk("rd_data", rd_data, mrd);
    end
  end

  task automatic tick();
    gray_req  = 1'($urandom_range(1));
    gray_addr = ADDR_W'($urandom);
    rd_addr   = ADDR_W'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // mode 0: data=i[7:0]; 1: random data, stray lbp beat at ptr 10; 2: random, finish at ptr 5.
  task automatic load_img(input int mode);
    for (int i = 0; i < DEPTH; i++) begin
      while ($urandom_range(7) == 0) begin load_valid = 1'b0; tick(); end
      load_valid = 1'b1;
      load_data  = (mode == 0) ? i[7:0] : DATA_W'($urandom);
      lbp_valid  = (mode == 1 && i == 10);
      lbp_data   = 8'hAA;
      finish     = (mode == 2 && i == 5);
      tick();
      lbp_valid = 1'b0;
      finish    = 1'b0;
    end
    load_valid = 1'b0;
  endtask

  task automatic wr(input int addr, input int data);
    while ($urandom_range(15) == 0) tick();
    lbp_valid = 1'b1;
    lbp_addr  = ADDR_W'(addr);
    lbp_data  = DATA_W'(data);
    tick();
    lbp_valid = 1'b0;
  endtask

  initial begin
    // Scenario A: full image, full in-order result stream.
    do_reset();
    started = 1'b1;
    chk("rst_load_ready", load_ready, 1);
    chk("rst_gray_ready", gray_ready, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_rd_data", rd_data, 0);
    load_img(0);
    chk("A_gray_ready", gray_ready, 1);
    chk("A_load_ready", load_ready, 0);
    gray_req = 1'b1; gray_addr = 14'd300; #2;
    chk("A_gray_300", gray_data, 8'h2C);
    for (int a = 0; a < DEPTH - 1; a++) wr(a, 1);
    lbp_valid = 1'b1; lbp_addr = ADDR_W'(DEPTH - 1); lbp_data = 8'h01; finish = 1'b1;
    tick();
    lbp_valid = 1'b0; finish = 1'b0;
    chk("A_wr_cnt", wr_cnt, 16384);
    chk("A_csum", csum, 16384);
    chk("A_done", done, 1);
    chk("A_errs", {err_order, err_early, err_count}, 0);
    rd_addr = 14'd5;
    @(posedge clk); #1;
    chk("A_rd_5", rd_data, 8'h01);
    for (int k = 0; k < 20; k++) tick();

    // Scenario B: early beat, ordering error, short count, activity in DONE.
    do_reset();
    load_img(1);
    chk("B_err_early", err_early, 1);
    chk("B_wr_cnt0", wr_cnt, 0);
    chk("B_csum0", csum, 0);
    wr(0, $urandom_range(255));
    wr(1, $urandom_range(255));
    chk("B_order_ok", err_order, 0);
    wr(3, $urandom_range(255));
    chk("B_err_order", err_order, 1);
    for (int a = 4; a <= 100; a++) wr(a, $urandom_range(255));
    finish = 1'b1; tick(); finish = 1'b0;
    chk("B_wr_cnt", wr_cnt, 100);
    chk("B_err_count", err_count, 1);
    chk("B_done", done, 1);
    for (int k = 0; k < 20; k++) begin
      load_valid = 1'b1; load_data = DATA_W'($urandom);
      lbp_valid = 1'($urandom_range(1)); lbp_addr = ADDR_W'($urandom_range(100));
      tick();
    end
    load_valid = 1'b0; lbp_valid = 1'b0;
    chk("B_load_ready_done", load_ready, 0);
    for (int k = 0; k < 20; k++) tick();

    // Scenario C: finish during load, then reset in the middle of SERVE.
    do_reset();
    load_img(2);
    chk("C_err_early", err_early, 1);
    for (int a = 0; a < 50; a++) wr(a, $urandom_range(255));
    chk("C_wr_cnt50", wr_cnt, 50);
    reset = 1'b1; #2;
    chk("C_load_ready", load_ready, 1);
    chk("C_gray_ready", gray_ready, 0);
    chk("C_wr_cnt", wr_cnt, 0);
    chk("C_err_early_clr", err_early, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 10; k++) tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
